display_mux: RTL and testbench
==============================

DISPLAY_MUX -- requirements
Module: display_mux

Interface
REQ-001 SHALL have parameter DIV_W, default 18: width of the phase counter; one display phase lasts 2^DIV_W clk cycles.
REQ-002 SHALL have parameter BLANK_CYC, default 64: number of blanked cycles at the start of each phase (used only when BLANK_EN is defined).
REQ-003 SHALL have port clk, input, 1, the single system clock; all state SHALL be clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port s0, input, 4, hex digit shown on digit 0 (DIP bank 0).
REQ-006 SHALL have port s1, input, 4, hex digit shown on digit 1 (DIP bank 1).
REQ-007 SHALL have port seg, output, 7, shared segment bus {g,f,e,d,c,b,a}, active-low.
REQ-008 SHALL have port an0, output, 1, digit-0 enable, active-low.
REQ-009 SHALL have port an1, output, 1, digit-1 enable, active-low.

Function
REQ-010 SHALL keep counter cnt[DIV_W-1:0], incremented every cycle and wrapping from all-ones to 0.
REQ-011 SHALL keep phase bit sel (0 = digit 0, 1 = digit 1), toggled on the edge where cnt wraps.
REQ-012 On each wrap edge, SHALL latch the operand of the new phase into the 4-bit digit register: s0 if new sel=0, s1 if new sel=1.
REQ-013 SHALL ignore changes on s0/s1 between wrap edges; the shown value SHALL change only at the next matching phase start.
REQ-014 seg, an0 and an1 SHALL be registered outputs computed from the next-state cnt, sel and digit, so they change on the same edge as the state.
REQ-015 When not blanked: an0 = sel_next, an1 = ~sel_next, seg = hex decode of digit_next.
REQ-016 an0 and an1 SHALL never be low in the same cycle.
REQ-017 When blanked: an0 = an1 = 1 and seg = 7'h7F.
REQ-018 Hex decode SHALL be 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex, active-low).

Reset
REQ-019 While reset is high: cnt = all-ones, sel = 1, digit = 0, an0 = an1 = 1, seg = 7'h7F, regardless of clk.
REQ-020 The first edge after reset deasserts SHALL wrap cnt to 0, set sel = 0 and latch s0, so digit 0 is always the first phase shown.
REQ-021 Reset asserted mid-phase SHALL blank the display immediately (asynchronously), with no partial digit retained.

Configuration
REQ-022 Macro DISPLAY_MUX_BLANK_EN SHALL compile in inter-digit blanking.
REQ-023 With DISPLAY_MUX_BLANK_EN defined, the display SHALL be blanked while cnt_next < BLANK_CYC; BLANK_CYC = 0 SHALL mean no blanking.
REQ-024 Without DISPLAY_MUX_BLANK_EN, the display SHALL never be blanked outside reset, and BLANK_CYC SHALL be unused.

Structure
REQ-025 Package display_pkg SHALL hold SEG_OFF (7'h7F), the active-low anode OFF/ON constants and the 16-entry decode table.
REQ-026 Hex-to-segment decode SHALL be a separate combinational sub-module, seg_decoder (4-bit in, 7-bit active-low out), instantiated once.

Verification (DIV_W=4, BLANK_CYC=2)
REQ-027 Reset release, s0=3, s1=A, macro off -> first edge: an0=0, an1=1, seg=30; 16 edges later: an0=1, an1=0, seg=08; alternation continues every 16 edges.
REQ-028 Macro on, same stimulus -> first 2 cycles of each phase: an0=an1=1, seg=7F; cycles 3-16: the correct digit is lit.
REQ-029 s0 changes 3->7 mid digit-0 phase -> seg holds 30 until the next digit-0 phase, which shows 78.
REQ-030 Sweep s0 through 0-F, one value per digit-0 phase -> seg matches every REQ-018 entry.
REQ-031 reset pulsed high mid digit-1 phase -> outputs 7F/1/1 immediately, with no clk edge required; after release the first lit phase is digit 0.
REQ-032 All phases of every test -> assertion an0|an1 always true; no cycle has both anodes low.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and hex-to-segment table for the display multiplexer
package display_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic       AN_OFF  = 1'b1;
    localparam logic       AN_ON   = 1'b0;

    // Segment order {g,f,e,d,c,b,a}, active-low; lower-case b and d keep them distinct from 8 and 0
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] digit);
        return SEG_TABLE[digit];
    endfunction

endpackage

// File: rtl/display_mux_if.sv
// rtl/display_mux_if.sv - digit operand and display drive signals of the display multiplexer
interface display_mux_if;

    logic [3:0] s0;
    logic [3:0] s1;
    logic [6:0] seg;
    logic       an0;
    logic       an1;

    modport master (
        output s0,
        output s1,
        input  seg,
        input  an0,
        input  an1
    );

    modport slave (
        input  s0,
        input  s1,
        output seg,
        output an0,
        output an1
    );

endinterface

// File: rtl/seg_decoder.sv
// rtl/seg_decoder.sv - combinational hex digit to active-low seven-segment decode
module seg_decoder
    import display_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = hex_to_seg(digit_i);
    end

endmodule

// File: rtl/display_mux.sv
// rtl/display_mux.sv - two-digit time-multiplexed seven-segment driver
// Optional inter-digit blanking is compiled in with DISPLAY_MUX_BLANK_EN.
module display_mux
    import display_pkg::*;
#(
    parameter int unsigned DIV_W     = 18,
    parameter int unsigned BLANK_CYC = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    output logic [6:0] seg,
    output logic       an0,
    output logic       an1
);

    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic [3:0]       digit_q, digit_d;
    logic [6:0]       seg_q, seg_d;
    logic             an0_q, an0_d;
    logic             an1_q, an1_d;
    logic [6:0]       seg_dec;
    logic             wrap;
    logic             blank_d;

    // Operands are sampled only at a phase start so a digit never changes while lit
    always_comb begin
        wrap    = &cnt_q;
        cnt_d   = cnt_q + CNT_ONE;
        sel_d   = sel_q;
        digit_d = digit_q;
        if (wrap) begin
            sel_d   = ~sel_q;
            digit_d = sel_q ? s0 : s1;
        end
    end

`ifdef DISPLAY_MUX_BLANK_EN
    assign blank_d = (BLANK_CYC != 0) && (32'(cnt_d) < BLANK_CYC);
`else
    // Parameter stays in the port list so both builds share one instantiation
    assign blank_d = 1'b0 & (BLANK_CYC != 0);
`endif

    seg_decoder u_seg_decoder (
        .digit_i (digit_d),
        .seg_o   (seg_dec)
    );

    always_comb begin
        seg_d = seg_dec;
        an0_d = sel_d;
        an1_d = ~sel_d;
        if (blank_d) begin
            seg_d = SEG_OFF;
            an0_d = AN_OFF;
            an1_d = AN_OFF;
        end
    end

    // Reset parks the counter at all-ones so the first edge starts the digit-0 phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '1;
            sel_q   <= 1'b1;
            digit_q <= 4'h0;
            seg_q   <= SEG_OFF;
            an0_q   <= AN_OFF;
            an1_q   <= AN_OFF;
        end else begin
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
            an0_q   <= an0_d;
            an1_q   <= an1_d;
        end
    end

    assign seg = seg_q;
    assign an0 = an0_q;
    assign an1 = an1_q;

endmodule

// File: tb/tb_display_mux.sv
// tb/tb_display_mux.sv - scoreboard bench for display_mux (DIV_W=4, BLANK_CYC=2)
module tb_display_mux;

    localparam int unsigned DIV_W     = 4;
    localparam int unsigned BLANK_CYC = 2;

    typedef struct packed {
        logic [6:0] seg;
        logic       an0;
        logic       an1;
    } exp_t;

    logic clk;
    logic reset;
    display_mux_if bus ();

    display_mux #(
        .DIV_W     (DIV_W),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .s0    (bus.s0),
        .s1    (bus.s1),
        .seg   (bus.seg),
        .an0   (bus.an0),
        .an1   (bus.an1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] hex_ref [16];
    exp_t       exp_q [$];
    int         errors = 0;
    int         checks = 0;

    logic [3:0] m_cnt;
    logic       m_sel;
    logic [3:0] m_dig;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 4'hF;
        m_sel = 1'b1;
        m_dig = 4'h0;
    endtask

    task automatic check_off(input string tag);
        check({tag, "_seg"}, 32'(bus.seg), 32'h7F);
        check({tag, "_an0"}, 32'(bus.an0), 32'h1);
        check({tag, "_an1"}, 32'(bus.an1), 32'h1);
    endtask

    // Predict the outputs after the coming edge, then compare once the edge has passed
    task automatic step();
        exp_t e;
        logic wrap;
        logic bl;
        wrap  = (m_cnt == 4'hF);
        m_cnt = m_cnt + 4'h1;
        if (wrap) begin
            m_sel = ~m_sel;
            m_dig = m_sel ? bus.s1 : bus.s0;
        end
`ifdef DISPLAY_MUX_BLANK_EN
        bl = (32'(m_cnt) < BLANK_CYC);
`else
        bl = 1'b0;
`endif
        e.seg = bl ? 7'h7F : hex_ref[m_dig];
        e.an0 = bl ? 1'b1 : m_sel;
        e.an1 = bl ? 1'b1 : ~m_sel;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("seg", 32'(bus.seg), 32'(e.seg));
        check("an0", 32'(bus.an0), 32'(e.an0));
        check("an1", 32'(bus.an1), 32'(e.an1));
        check("an_excl", 32'(bus.an0 | bus.an1), 32'h1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        hex_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        reset  = 1'b1;
        bus.s0 = 4'h3;
        bus.s1 = 4'hA;
        model_reset();
        #2;
        check_off("rst_async");
        repeat (3) @(posedge clk);
        #1;
        check_off("rst_hold");

        @(negedge clk);
        reset = 1'b0;
        run(1);
`ifndef DISPLAY_MUX_BLANK_EN
        check("first_seg", 32'(bus.seg), 32'h30);
        check("first_an0", 32'(bus.an0), 32'h0);
`endif
        run(15);
        run(1);
`ifndef DISPLAY_MUX_BLANK_EN
        check("second_seg", 32'(bus.seg), 32'h08);
        check("second_an1", 32'(bus.an1), 32'h0);
`endif
        run(47);

        // Operand change mid digit-0 phase must not show until the next digit-0 phase
        run(6);
        bus.s0 = 4'h7;
        run(10);
        run(32);

        for (int v = 0; v < 16; v++) begin
            bus.s0 = 4'(v);
            bus.s1 = 4'(15 - v);
            run(32);
        end

        // Async reset in the middle of a digit-1 phase
        run(16 + 5);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_off("rst_mid");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_off("rst_mid_hold");
        @(negedge clk);
        reset = 1'b0;
        run(1);
`ifndef DISPLAY_MUX_BLANK_EN
        check("rst_first_an0", 32'(bus.an0), 32'h0);
`endif
        run(47);

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
